// File: rtl/count_sequencer.sv
// Run-control sequencer for an external WIDTH-bit counter: command handshake, tick prescaler, terminal detect.
// Optional feature macro: COUNT_SEQ_AUTORELOAD_EN (terminal tick clears the counter and keeps running).
`timescale 1ns/1ps
module count_sequencer #(
    parameter int               WIDTH = 8,
    parameter int               DIV   = 4,
    parameter logic [WIDTH-1:0] TERM  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             cnt_ld,
    output logic [WIDTH-1:0] cnt_ld_val,
    output logic [1:0]       state_o,
    output logic             done
);

    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        C_START = 2'd0,
        C_STOP  = 2'd1,
        C_CLEAR = 2'd2,
        C_LOAD  = 2'd3
    } cmd_t;

    state_t           state_reg;
    logic [PW-1:0]    presc_reg;
    logic             cmd_ready_reg;
    logic             cnt_en_reg;
    logic             cnt_clr_reg;
    logic             cnt_ld_reg;
    logic [WIDTH-1:0] cnt_ld_val_reg;
    logic             done_reg;

    logic accept;
    logic tick;
    logic at_term;

    assign accept  = cmd_valid && cmd_ready_reg;
    assign tick    = (state_reg == S_RUN) && (presc_reg == PRESC_LAST);
    assign at_term = (cnt_value == TERM);

    // An accepted command owns its cycle: the prescaler neither advances nor
    // wraps, so a pending tick is dropped and only the command may move it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            presc_reg      <= '0;
            cmd_ready_reg  <= 1'b1;
            cnt_en_reg     <= 1'b0;
            cnt_clr_reg    <= 1'b0;
            cnt_ld_reg     <= 1'b0;
            cnt_ld_val_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            cmd_ready_reg <= !accept;
            cnt_en_reg    <= 1'b0;
            cnt_clr_reg   <= 1'b0;
            cnt_ld_reg    <= 1'b0;
`ifdef COUNT_SEQ_AUTORELOAD_EN
            done_reg      <= 1'b0;
`endif
            if (accept) begin
                case (cmd_t'(cmd))
                    C_START: begin
                        if (state_reg == S_IDLE) begin
                            state_reg <= S_RUN;
                            presc_reg <= '0;
                        end else if (state_reg == S_PAUSE) begin
                            state_reg <= S_RUN;
                        end
                    end
                    C_STOP: begin
                        if (state_reg == S_RUN) begin
                            state_reg <= S_PAUSE;
                        end
                    end
                    C_CLEAR: begin
                        state_reg   <= S_IDLE;
                        presc_reg   <= '0;
                        done_reg    <= 1'b0;
                        cnt_clr_reg <= 1'b1;
                    end
                    C_LOAD: begin
                        cnt_ld_reg     <= 1'b1;
                        cnt_ld_val_reg <= cmd_data;
                        if (state_reg == S_DONE) begin
                            state_reg <= S_IDLE;
                            done_reg  <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (state_reg == S_RUN) begin
                if (tick) begin
                    presc_reg <= '0;
                    if (at_term) begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
                        cnt_clr_reg <= 1'b1;
                        done_reg    <= 1'b1;
`else
                        state_reg   <= S_DONE;
                        done_reg    <= 1'b1;
`endif
                    end else begin
                        cnt_en_reg <= 1'b1;
                    end
                end else begin
                    presc_reg <= presc_reg + 1'b1;
                end
            end
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign cnt_en     = cnt_en_reg;
    assign cnt_clr    = cnt_clr_reg;
    assign cnt_ld     = cnt_ld_reg;
    assign cnt_ld_val = cnt_ld_val_reg;
    assign state_o    = state_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: DIV=4/TERM=5 instance driven by a vector table and hand sequences, plus a DIV=1 instance.
// Define COUNT_SEQ_AUTORELOAD_EN at build time to check the auto-reload variant.
`timescale 1ns/1ps
module tb_count_sequencer;

    localparam int         W       = 8;
    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_STOP  = 2'd1;
    localparam logic [1:0] C_CLEAR = 2'd2;
    localparam logic [1:0] C_LOAD  = 2'd3;

    logic         clk;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd;
    logic [W-1:0] cmd_data, cnt_value, cnt_ld_val;
    logic         cnt_en, cnt_clr, cnt_ld, done;
    logic [1:0]   state_o;

    logic         cmd_valid_b, cmd_ready_b;
    logic [1:0]   cmd_b;
    logic [W-1:0] cmd_data_b, cnt_value_b, cnt_ld_val_b;
    logic         cnt_en_b, cnt_clr_b, cnt_ld_b, done_b;
    logic [1:0]   state_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];
    logic en_prev = 1'b0;

    typedef struct {
        logic         v;
        logic [1:0]   c;
        logic [W-1:0] d;
        logic [1:0]   st;
        logic         rdy, en, clr, ld, dn;
    } vec_t;
    vec_t vecs[8];

    count_sequencer #(.WIDTH(W), .DIV(4), .TERM(8'h05)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .cnt_ld(cnt_ld), .cnt_ld_val(cnt_ld_val), .state_o(state_o), .done(done)
    );

    count_sequencer #(.WIDTH(W), .DIV(1), .TERM(8'hFF)) dut_div1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd(cmd_b), .cmd_data(cmd_data_b),
        .cmd_ready(cmd_ready_b), .cnt_value(cnt_value_b), .cnt_en(cnt_en_b), .cnt_clr(cnt_clr_b),
        .cnt_ld(cnt_ld_b), .cnt_ld_val(cnt_ld_val_b), .state_o(state_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Display-counter datapath that the sequencer controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt_value <= '0;
        else if (cnt_clr) cnt_value <= '0;
        else if (cnt_ld)  cnt_value <= cnt_ld_val;
        else if (cnt_en)  cnt_value <= cnt_value + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cnt_value_b <= '0;
        else if (cnt_clr_b) cnt_value_b <= '0;
        else if (cnt_ld_b)  cnt_value_b <= cnt_ld_val_b;
        else if (cnt_en_b)  cnt_value_b <= cnt_value_b + 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_strobes_done"}, 32'({cnt_en, cnt_clr, cnt_ld, done}), 32'd0);
        check({tag, "_ld_val"}, 32'(cnt_ld_val), 32'd0);
    endtask

    // One clock of the main instance; the scoreboard pops the expected counter
    // value whenever the cycle before carried cnt_en.
    task automatic cyc(input logic v, input logic [1:0] c, input logic [W-1:0] d);
        cmd_valid = v;
        cmd       = c;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("strobes_exclusive", 32'($onehot0({cnt_en, cnt_clr, cnt_ld})), 32'd1);
        if (en_prev) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL cnt_en_unexpected: counter now %0d, no increment expected", cnt_value);
            end else begin
                check("cnt_value", 32'(cnt_value), 32'(exp_q.pop_front()));
            end
        end
        en_prev = cnt_en;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  since_en;
        int  n_en;
        bit  reached;

        //                v     cmd      data   st    rdy   en    clr   ld    done
        vecs[0] = '{1'b1, C_CLEAR, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, C_START, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, C_START, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, C_STOP,  8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, C_START, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, C_START, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, C_START, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, C_START, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd = 2'd0; cmd_data = '0;
        cmd_valid_b = 1'b0; cmd_b = 2'd0; cmd_data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        check("por_div1_state_ready", 32'({state_b, cmd_ready_b}), 32'({2'd0, 1'b1}));
        rst = 1'b0;

        // CLEAR, START (a STOP during cmd_ready=0 is ignored), first tick
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                for (int k = 1; k <= 5; k++) exp_q.push_back(k);
            end
            cyc(vecs[i].v, vecs[i].c, vecs[i].d);
            check($sformatf("vec%0d", i),
                  32'({state_o, cmd_ready, cnt_en, cnt_clr, cnt_ld, done}),
                  32'({vecs[i].st, vecs[i].rdy, vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].dn}));
        end

        // count up to the terminal value, ticks every 4 cycles
        since_en = 1;
        n_en     = 1;
        reached  = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            cyc(1'b0, C_START, '0);
            since_en++;
            if (cnt_en) begin
                check("en_spacing", 32'(since_en), 32'd4);
                since_en = 0;
                n_en++;
            end
`ifdef COUNT_SEQ_AUTORELOAD_EN
            if (cnt_clr) begin
`else
            if (state_o == 2'd3) begin
`endif
                reached = 1'b1;
                check("terminal_delay", 32'(since_en), 32'd4);
            end
        end
        check("terminal_reached", 32'(reached), 32'd1);
        check("en_count", 32'(n_en), 32'd5);
        check("counter_at_terminal", 32'(cnt_value), 32'd5);

`ifdef COUNT_SEQ_AUTORELOAD_EN
        check("reload_pulse", 32'({state_o, cnt_en, cnt_clr, done}), 32'({2'd1, 1'b0, 1'b1, 1'b1}));
        exp_q.push_back(1);
        cyc(1'b0, C_START, '0);
        check("reload_after", 32'({state_o, cnt_clr, done}), 32'({2'd1, 1'b0, 1'b0}));
        check("reload_counter_zero", 32'(cnt_value), 32'd0);
        repeat (3) cyc(1'b0, C_START, '0);
        check("reload_next_en", 32'(cnt_en), 32'd1);
        cyc(1'b1, C_CLEAR, '0);
        cyc(1'b0, C_START, '0);
        check("reload_cleared", 32'({state_o, cnt_value}), 32'({2'd0, 8'd0}));
`else
        check("done_level", 32'({state_o, done}), 32'({2'd3, 1'b1}));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, C_START, '0);
            check($sformatf("done_hold_%0d", k), 32'({state_o, done, cnt_en, cnt_value}),
                  32'({2'd3, 1'b1, 1'b0, 8'd5}));
        end
`endif

        // LOAD: accepted only on alternate cycles of a back-to-back stream
        cyc(1'b1, C_LOAD, 8'h03);
        check("load3", 32'({state_o, cmd_ready, cnt_ld, done, cnt_en, cnt_clr}),
              32'({2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        check("load3_val", 32'(cnt_ld_val), 32'h03);
        cyc(1'b1, C_LOAD, 8'h07);
        check("load7_ignored", 32'({cmd_ready, cnt_ld, cnt_value}), 32'({1'b1, 1'b0, 8'h03}));
        cyc(1'b1, C_LOAD, 8'h09);
        check("load9", 32'({cmd_ready, cnt_ld, cnt_ld_val}), 32'({1'b0, 1'b1, 8'h09}));
        cyc(1'b1, C_CLEAR, '0);
        check("clear_ignored", 32'({state_o, cmd_ready, cnt_clr, cnt_value}),
              32'({2'd0, 1'b1, 1'b0, 8'h09}));
        cyc(1'b1, C_CLEAR, '0);
        check("clear_taken", 32'({cmd_ready, cnt_clr}), 32'({1'b0, 1'b1}));
        cyc(1'b0, C_START, '0);
        check("clear_counter", 32'({cmd_ready, cnt_value}), 32'({1'b1, 8'h00}));

        // START, STOP after two ticks at prescaler phase 1, pause, resume
        exp_q.push_back(1);
        exp_q.push_back(2);
        cyc(1'b1, C_START, '0);
        check("run_start", 32'(state_o), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b0, C_START, '0);
            check($sformatf("run_en_%0d", k), 32'(cnt_en), (k == 4 || k == 8) ? 32'd1 : 32'd0);
        end
        cyc(1'b1, C_STOP, '0);
        check("stop", 32'({state_o, cnt_en}), 32'({2'd2, 1'b0}));
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, C_START, '0);
            check($sformatf("pause_%0d", k), 32'({state_o, cnt_en, cnt_value}), 32'({2'd2, 1'b0, 8'd2}));
        end
        exp_q.push_back(3);
        cyc(1'b1, C_START, '0);
        check("resume", 32'({state_o, cnt_en}), 32'({2'd1, 1'b0}));
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, C_START, '0);
            check($sformatf("resume_en_%0d", k), 32'(cnt_en), (k == 3) ? 32'd1 : 32'd0);
        end

        // STOP on the exact tick edge: tick dropped, prescaler frozen at its last phase
        repeat (3) cyc(1'b0, C_START, '0);
        cyc(1'b1, C_STOP, '0);
        check("stop_on_tick", 32'({state_o, cnt_en, cnt_value}), 32'({2'd2, 1'b0, 8'd3}));
        cyc(1'b0, C_START, '0);
        check("stop_on_tick_hold", 32'({state_o, cnt_en}), 32'({2'd2, 1'b0}));
        exp_q.push_back(4);
        cyc(1'b1, C_START, '0);
        check("resume_phase3", 32'({state_o, cnt_en}), 32'({2'd1, 1'b0}));
        cyc(1'b0, C_START, '0);
        check("resume_phase3_en", 32'(cnt_en), 32'd1);
        cyc(1'b0, C_START, '0);

        // LOAD while running keeps RUN; then reset with a cnt_en in flight
        cyc(1'b1, C_LOAD, 8'h02);
        check("load_in_run", 32'({state_o, cnt_ld, cnt_en}), 32'({2'd1, 1'b1, 1'b0}));
        cyc(1'b0, C_START, '0);
        check("load_in_run_cnt", 32'(cnt_value), 32'd2);
        cyc(1'b0, C_START, '0);
        cyc(1'b0, C_START, '0);
        check("en_before_reset", 32'(cnt_en), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("rst_async");
        exp_q.delete();
        en_prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_reset($sformatf("rst_hold%0d", k));
        end
        rst = 1'b0;
        cyc(1'b0, C_START, '0);
        check_reset("rst_release");
        check("rst_counter", 32'(cnt_value), 32'd0);

        // DIV=1: cnt_en held high throughout RUN
        cmd_valid_b = 1'b1;
        cmd_b       = C_START;
        @(posedge clk);
        #1;
        cmd_valid_b = 1'b0;
        check("div1_start", 32'({state_b, cnt_en_b}), 32'({2'd1, 1'b0}));
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("div1_en_%0d", k), 32'({state_b, cnt_en_b}), 32'({2'd1, 1'b1}));
        end
        check("div1_count", 32'(cnt_value_b), 32'd9);
        cmd_valid_b = 1'b1;
        cmd_b       = C_STOP;
        @(posedge clk);
        #1;
        cmd_valid_b = 1'b0;
        check("div1_stop", 32'({state_b, cnt_en_b}), 32'({2'd2, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
